drum_step_scheduler: RTL and testbench
======================================

Name: drum_step_scheduler

Overview:
- Sequences the row-serial finite-difference drum mesh (square solver with an 18-bit signed output node) through successive time steps.
- Each step: sweeps row addresses into the column solvers' M10K read ports and issues write-backs after a fixed pipeline latency.
- Swaps the u(n)/u(n-1) buffers and paces steps to the audio sample tick.
- Counts iterations against max_iterations and flags done; sits between the audio/HPS control logic and the mesh datapath.

Parameters:
- N_ROWS, 32, mesh rows per column, ≥2.
- ROW_W, 5, row index width; must equal clog2(N_ROWS).
- PIPE_LAT, 3, cycles from rd_en to matching wr_en (M10K read plus compute), ≥1.
- OUT_ROW, 16, row whose write-back carries the output node; must be < N_ROWS.

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; begins a run; ignored while busy.
- max_iterations  in  32  steps per run; sampled on accepted start.
- sample_tick  in  1  audio-rate strobe, one cycle wide.
- rd_en  out  1  read/compute enable for row rd_row.
- rd_row  out  ROW_W  row being read.
- wr_en  out  1  write-back enable for row wr_row.
- wr_row  out  ROW_W  row being written.
- first_row  out  1  rd_en && rd_row==0 (boundary handling).
- last_row  out  1  rd_en && rd_row==N_ROWS-1.
- buf_sel  out  1  ping-pong select for the current-step buffer.
- capture_en  out  1  wr_en && wr_row==OUT_ROW; latches output_node.
- step_done  out  1  one-cycle pulse at the end of each step.
- iterations  out  32  completed steps in the current run.
- busy  out  1  high in SWEEP, DRAIN and WAIT_TICK.
- done  out  1  held high in DONE.
- overrun  out  1  sticky; a tick arrived while one was already pending.

Behaviour:
- Reset (rst low, async): all outputs 0, state IDLE, row counter 0, tick_pending 0, wr delay line cleared.
- States: IDLE, SWEEP, DRAIN, WAIT_TICK, DONE.
- IDLE or DONE, start=1:
  - Latch max_iterations, clear iterations and overrun, clear done.
  - If latched max==0: go to DONE (done=1 next cycle, no rd_en).
  - Otherwise go to SWEEP. The first step does not wait for a tick.
- SWEEP:
  - rd_en=1 for exactly N_ROWS consecutive cycles; rd_row = 0..N_ROWS-1.
  - After the cycle with rd_row==N_ROWS-1, go to DRAIN.
- wr_en/wr_row are rd_en/rd_row delayed by exactly PIPE_LAT cycles through a shift register. Never forced; only cleared by reset.
- DRAIN:
  - Lasts PIPE_LAT cycles; the final wr_en (wr_row==N_ROWS-1) occurs in the last DRAIN cycle.
  - On that cycle, registered: iterations+=1, buf_sel toggles, step_done=1 the following cycle.
  - Next state is DONE if the new iterations == latched max, otherwise WAIT_TICK.
- WAIT_TICK:
  - If tick_pending or sample_tick is set: clear tick_pending and go to SWEEP next cycle.
  - Minimum step period = N_ROWS+PIPE_LAT+1 cycles.
- Tick handling:
  - sample_tick in SWEEP/DRAIN sets tick_pending.
  - A tick while tick_pending is already 1 sets overrun; the extra tick is dropped.
  - Ticks in IDLE/DONE are ignored.
- Run completion: done stays 1 until the next accepted start. iterations holds its final value.
- buf_sel is not reset by start; it persists across runs and only reset clears it.
- Reset mid-sweep: immediate return to IDLE; in-flight writes are discarded.

Decomposition:
- Package drum_pkg:
  - state enum (IDLE, SWEEP, DRAIN, WAIT_TICK, DONE).
  - default N_ROWS, PIPE_LAT and OUT_ROW constants.
  - ROW_W derived via $clog2.
- Sub-module drum_delay_line: parameterised PIPE_LAT-deep register shift carrying {valid, row}, async active-low reset.

Test Plan (N_ROWS=4, PIPE_LAT=3, OUT_ROW=2):
1. Release reset at 40 ns with no start: all outputs 0 and stay 0 for 20 cycles.
2. start with max=10 and sample_tick on every 8th cycle:
   - rd_row 0,1,2,3 in cycles 1-4 after start; wr_row 0..3 in cycles 4-7.
   - capture_en once per step; 10 step_done pulses, buf_sel toggling each time.
   - done=1 with iterations=10; no rd_en afterwards.
3. max=0: done=1 one cycle after start; rd_en never asserted; iterations=0.
4. max=3 with tick held continuously available: steps back-to-back at exactly 8 cycles; overrun stays 0.
5. Two ticks during one SWEEP: overrun=1 and stays sticky; exactly one next step starts. A new start clears overrun.
6. Reset asserted during SWEEP at rd_row=2: outputs 0 asynchronously; no wr_en after release; a following start behaves as in scenario 2.

Source files
------------

// File: rtl/drum_pkg.sv
// Shared definitions for the drum mesh step scheduler: FSM states and
// default mesh geometry / pipeline depth.
package drum_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SWEEP,
      DRAIN,
      WAIT_TICK,
      DONE
   } state_t;

   localparam int DEF_N_ROWS   = 32;
   localparam int DEF_PIPE_LAT = 3;
   localparam int DEF_OUT_ROW  = 16;
   localparam int DEF_ROW_W    = $clog2(DEF_N_ROWS);

endpackage

// File: rtl/drum_delay_line.sv
// Fixed-depth shift register that re-times each row read into its
// matching write-back, carrying a valid bit alongside the row index.
module drum_delay_line #(
   parameter int PIPE_LAT = 3,
   parameter int ROW_W    = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [ROW_W-1:0] in_row,
   output logic             out_valid,
   output logic [ROW_W-1:0] out_row
);

   logic [PIPE_LAT-1:0] valid_sr;
   logic [ROW_W-1:0]    row_sr [PIPE_LAT];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         valid_sr <= '0;
         for (int i = 0; i < PIPE_LAT; i++) begin
            row_sr[i] <= '0;
         end
      end else begin
         valid_sr[0] <= in_valid;
         row_sr[0]   <= in_row;
         for (int i = 1; i < PIPE_LAT; i++) begin
            valid_sr[i] <= valid_sr[i-1];
            row_sr[i]   <= row_sr[i-1];
         end
      end
   end

   assign out_valid = valid_sr[PIPE_LAT-1];
   assign out_row   = row_sr[PIPE_LAT-1];

endmodule

// File: rtl/drum_step_scheduler.sv
// Steps the row-serial drum mesh: sweeps rows, drains the compute pipeline,
// flips the u(n)/u(n-1) buffers and paces each step to the audio tick.
module drum_step_scheduler
   import drum_pkg::*;
#(
   parameter int N_ROWS   = DEF_N_ROWS,
   parameter int ROW_W    = $clog2(N_ROWS),
   parameter int PIPE_LAT = DEF_PIPE_LAT,
   parameter int OUT_ROW  = DEF_OUT_ROW
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [31:0]      max_iterations,
   input  logic             sample_tick,
   output logic             rd_en,
   output logic [ROW_W-1:0] rd_row,
   output logic             wr_en,
   output logic [ROW_W-1:0] wr_row,
   output logic             first_row,
   output logic             last_row,
   output logic             buf_sel,
   output logic             capture_en,
   output logic             step_done,
   output logic [31:0]      iterations,
   output logic             busy,
   output logic             done,
   output logic             overrun
);

   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(N_ROWS - 1);
   localparam logic [ROW_W-1:0] CAP_ROW  = ROW_W'(OUT_ROW);

   state_t           state, next_state;
   logic [ROW_W-1:0] row_cnt;
   logic [31:0]      max_latched;
   logic [31:0]      iter_next;
   logic             tick_pending;
   logic             accept_start;
   logic             step_end;
   logic             tick_in_step;

   // The write-back that lands on the last row closes the step.
   assign iter_next    = iterations + 32'd1;
   assign step_end     = (state == DRAIN) && wr_en && (wr_row == LAST_ROW);
   assign tick_in_step = sample_tick && ((state == SWEEP) || (state == DRAIN));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state   = state;
      accept_start = 1'b0;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               accept_start = 1'b1;
               next_state   = (max_iterations == 32'd0) ? DONE : SWEEP;
            end
         end
         SWEEP: begin
            if (row_cnt == LAST_ROW) begin
               next_state = DRAIN;
            end
         end
         DRAIN: begin
            if (step_end) begin
               next_state = (iter_next == max_latched) ? DONE : WAIT_TICK;
            end
         end
         WAIT_TICK: begin
            if (tick_pending || sample_tick) begin
               next_state = SWEEP;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Step bookkeeping; a tick arriving mid-step is banked so the next step
   // can begin immediately, and a second one while banked is an overrun.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         row_cnt      <= '0;
         max_latched  <= '0;
         iterations   <= '0;
         buf_sel      <= 1'b0;
         step_done    <= 1'b0;
         tick_pending <= 1'b0;
         overrun      <= 1'b0;
      end else begin
         step_done <= 1'b0;
         row_cnt   <= ((state == SWEEP) && (row_cnt != LAST_ROW)) ? row_cnt + 1'b1 : '0;
         if (accept_start) begin
            max_latched  <= max_iterations;
            iterations   <= '0;
            overrun      <= 1'b0;
            tick_pending <= 1'b0;
         end
         if (step_end) begin
            iterations <= iter_next;
            buf_sel    <= ~buf_sel;
            step_done  <= 1'b1;
         end
         if (tick_in_step) begin
            if (tick_pending) begin
               overrun <= 1'b1;
            end else begin
               tick_pending <= 1'b1;
            end
         end else if ((state == WAIT_TICK) && (next_state == SWEEP)) begin
            tick_pending <= 1'b0;
         end
      end
   end

   drum_delay_line #(
      .PIPE_LAT (PIPE_LAT),
      .ROW_W    (ROW_W)
   ) u_delay (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (rd_en),
      .in_row    (rd_row),
      .out_valid (wr_en),
      .out_row   (wr_row)
   );

   assign rd_en      = (state == SWEEP);
   assign rd_row     = row_cnt;
   assign first_row  = rd_en && (rd_row == '0);
   assign last_row   = rd_en && (rd_row == LAST_ROW);
   assign capture_en = wr_en && (wr_row == CAP_ROW);
   assign busy       = (state == SWEEP) || (state == DRAIN) || (state == WAIT_TICK);
   assign done       = (state == DONE);

endmodule

// File: tb/tb_drum_step_scheduler.sv
// Self-checking bench for drum_step_scheduler on a 4-row mesh with a
// 3-cycle pipeline: per-cycle vector table plus multi-step sequences.
module tb_drum_step_scheduler;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [31:0] max_iterations;
   logic        sample_tick;
   logic        rd_en;
   logic [1:0]  rd_row;
   logic        wr_en;
   logic [1:0]  wr_row;
   logic        first_row;
   logic        last_row;
   logic        buf_sel;
   logic        capture_en;
   logic        step_done;
   logic [31:0] iterations;
   logic        busy;
   logic        done;
   logic        overrun;

   int checks   = 0;
   int failures = 0;
   logic exp_buf;
   int step_starts[$];

   // Flags order: {rd_en, first_row, last_row, wr_en, capture_en, step_done, buf_sel, busy, done}
   typedef struct {
      logic        start;
      logic [31:0] max_it;
      logic        tick;
      logic [8:0]  flags;
      logic [1:0]  rr;
      logic [1:0]  wrr;
      logic [31:0] iter;
   } vec_t;

   localparam int NV = 19;
   vec_t vecs[NV];

   drum_step_scheduler #(
      .N_ROWS   (4),
      .ROW_W    (2),
      .PIPE_LAT (3),
      .OUT_ROW  (2)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .max_iterations (max_iterations),
      .sample_tick    (sample_tick),
      .rd_en          (rd_en),
      .rd_row         (rd_row),
      .wr_en          (wr_en),
      .wr_row         (wr_row),
      .first_row      (first_row),
      .last_row       (last_row),
      .buf_sel        (buf_sel),
      .capture_en     (capture_en),
      .step_done      (step_done),
      .iterations     (iterations),
      .busy           (busy),
      .done           (done),
      .overrun        (overrun)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic vec_t mkVec(logic s, logic [31:0] m, logic t, logic [8:0] f,
                                  logic [1:0] rr, logic [1:0] wrr, logic [31:0] it);
      vec_t v;
      v.start = s; v.max_it = m; v.tick = t; v.flags = f;
      v.rr = rr; v.wrr = wrr; v.iter = it;
      return v;
   endfunction

   function automatic logic [63:0] packOutputs();
      return {18'd0, rd_en, rd_row, wr_en, wr_row, first_row, last_row, buf_sel,
              capture_en, step_done, busy, done, overrun, iterations};
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic s, input logic [31:0] m, input logic t);
      start          = s;
      max_iterations = m;
      sample_tick    = t;
   endtask

   task automatic wait_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic run_table();
      logic [8:0] flags;
      for (int i = 0; i < NV; i++) begin
         applyStimulus(vecs[i].start, vecs[i].max_it, vecs[i].tick);
         wait_cycle();
         flags = {rd_en, first_row, last_row, wr_en, capture_en, step_done, buf_sel, busy, done};
         checkOutput($sformatf("vec%0d flags", i), 64'(flags), 64'(vecs[i].flags));
         if (vecs[i].flags[8]) checkOutput($sformatf("vec%0d rd_row", i), 64'(rd_row), 64'(vecs[i].rr));
         if (vecs[i].flags[5]) checkOutput($sformatf("vec%0d wr_row", i), 64'(wr_row), 64'(vecs[i].wrr));
         checkOutput($sformatf("vec%0d iterations", i), 64'(iterations), 64'(vecs[i].iter));
      end
      applyStimulus(1'b0, 32'd0, 1'b0);
   endtask

   task automatic run_steps(input logic [31:0] m, input int period, input int phase);
      int steps = 0;
      int caps  = 0;
      int stray = 0;
      step_starts.delete();
      applyStimulus(1'b1, m, 1'b0);
      wait_cycle();
      for (int n = 1; n < 400; n++) begin
         if (rd_en && first_row) step_starts.push_back(n);
         if (capture_en) caps++;
         if (step_done) begin
            steps++;
            exp_buf = ~exp_buf;
            checkOutput($sformatf("buf_sel after step %0d", steps), 64'(buf_sel), 64'(exp_buf));
         end
         if (done) break;
         applyStimulus(1'b0, m, (n % period) == phase);
         wait_cycle();
      end
      checkOutput("run done", 64'(done), 64'd1);
      checkOutput("run step_done count", 64'(steps), 64'(m));
      checkOutput("run capture count", 64'(caps), 64'(m));
      checkOutput("run iterations", 64'(iterations), 64'(m));
      checkOutput("run overrun", 64'(overrun), 64'd0);
      applyStimulus(1'b0, m, 1'b0);
      for (int i = 0; i < 10; i++) begin
         wait_cycle();
         if (rd_en || wr_en) stray++;
      end
      checkOutput("no access after done", 64'(stray), 64'd0);
   endtask

   initial begin
      int cnt;
      vecs[0]  = mkVec(1'b1, 32'd2, 1'b0, 9'b110_000_010, 2'd0, 2'd0, 32'd0);
      vecs[1]  = mkVec(1'b0, 32'd0, 1'b0, 9'b100_000_010, 2'd1, 2'd0, 32'd0);
      vecs[2]  = mkVec(1'b0, 32'd0, 1'b0, 9'b100_000_010, 2'd2, 2'd0, 32'd0);
      vecs[3]  = mkVec(1'b0, 32'd0, 1'b0, 9'b101_100_010, 2'd3, 2'd0, 32'd0);
      vecs[4]  = mkVec(1'b0, 32'd0, 1'b0, 9'b000_100_010, 2'd0, 2'd1, 32'd0);
      vecs[5]  = mkVec(1'b0, 32'd0, 1'b0, 9'b000_110_010, 2'd0, 2'd2, 32'd0);
      vecs[6]  = mkVec(1'b0, 32'd0, 1'b0, 9'b000_100_010, 2'd0, 2'd3, 32'd0);
      vecs[7]  = mkVec(1'b0, 32'd0, 1'b0, 9'b000_001_110, 2'd0, 2'd0, 32'd1);
      vecs[8]  = mkVec(1'b0, 32'd0, 1'b0, 9'b000_000_110, 2'd0, 2'd0, 32'd1);
      vecs[9]  = mkVec(1'b0, 32'd0, 1'b1, 9'b110_000_110, 2'd0, 2'd0, 32'd1);
      vecs[10] = mkVec(1'b0, 32'd0, 1'b0, 9'b100_000_110, 2'd1, 2'd0, 32'd1);
      vecs[11] = mkVec(1'b0, 32'd0, 1'b0, 9'b100_000_110, 2'd2, 2'd0, 32'd1);
      vecs[12] = mkVec(1'b0, 32'd0, 1'b0, 9'b101_100_110, 2'd3, 2'd0, 32'd1);
      vecs[13] = mkVec(1'b0, 32'd0, 1'b0, 9'b000_100_110, 2'd0, 2'd1, 32'd1);
      vecs[14] = mkVec(1'b0, 32'd0, 1'b0, 9'b000_110_110, 2'd0, 2'd2, 32'd1);
      vecs[15] = mkVec(1'b0, 32'd0, 1'b0, 9'b000_100_110, 2'd0, 2'd3, 32'd1);
      vecs[16] = mkVec(1'b0, 32'd0, 1'b0, 9'b000_001_001, 2'd0, 2'd0, 32'd2);
      vecs[17] = mkVec(1'b0, 32'd0, 1'b1, 9'b000_000_001, 2'd0, 2'd0, 32'd2);
      vecs[18] = mkVec(1'b0, 32'd0, 1'b1, 9'b000_000_001, 2'd0, 2'd0, 32'd2);

      rst = 1'b0;
      applyStimulus(1'b0, 32'd0, 1'b0);
      exp_buf = 1'b0;
      #20;
      checkOutput("outputs in reset", packOutputs(), 64'd0);
      #20 rst = 1'b1;

      // Idle after reset: nothing moves without a start.
      for (int i = 0; i < 20; i++) begin
         wait_cycle();
         checkOutput($sformatf("idle cycle %0d", i), packOutputs(), 64'd0);
      end

      // Two-step run, cycle by cycle, including a wait for the tick.
      run_table();

      // Ten steps paced by a tick every 8 cycles.
      run_steps(32'd10, 8, 3);

      // Zero iterations finishes immediately without any read.
      applyStimulus(1'b1, 32'd0, 1'b0);
      wait_cycle();
      checkOutput("max0 done", 64'(done), 64'd1);
      checkOutput("max0 iterations", 64'(iterations), 64'd0);
      checkOutput("max0 busy", 64'(busy), 64'd0);
      applyStimulus(1'b0, 32'd0, 1'b0);
      cnt = (rd_en) ? 1 : 0;
      for (int i = 0; i < 5; i++) begin
         wait_cycle();
         if (rd_en) cnt++;
      end
      checkOutput("max0 no rd_en", 64'(cnt), 64'd0);
      checkOutput("max0 done held", 64'(done), 64'd1);

      // Back-to-back steps exactly 8 cycles apart.
      run_steps(32'd3, 8, 0);
      checkOutput("b2b start count", 64'(step_starts.size()), 64'd3);
      if (step_starts.size() == 3) begin
         checkOutput("b2b period 1", 64'(step_starts[1] - step_starts[0]), 64'd8);
         checkOutput("b2b period 2", 64'(step_starts[2] - step_starts[1]), 64'd8);
      end

      // Two ticks in one sweep: sticky overrun, only one step released.
      applyStimulus(1'b1, 32'd3, 1'b0);
      wait_cycle();
      applyStimulus(1'b0, 32'd3, 1'b1);
      wait_cycle();
      applyStimulus(1'b0, 32'd3, 1'b0);
      wait_cycle();
      applyStimulus(1'b0, 32'd3, 1'b1);
      wait_cycle();
      checkOutput("overrun after double tick", 64'(overrun), 64'd1);
      applyStimulus(1'b0, 32'd3, 1'b0);
      cnt = 0;
      for (int i = 0; i < 30; i++) begin
         wait_cycle();
         if (rd_en && first_row) cnt++;
      end
      checkOutput("single step released", 64'(cnt), 64'd1);
      checkOutput("waiting iterations", 64'(iterations), 64'd2);
      checkOutput("waiting busy", 64'(busy), 64'd1);
      checkOutput("overrun sticky", 64'(overrun), 64'd1);
      applyStimulus(1'b0, 32'd3, 1'b1);
      wait_cycle();
      applyStimulus(1'b0, 32'd3, 1'b0);
      for (int i = 0; i < 20 && !done; i++) wait_cycle();
      checkOutput("overrun run done", 64'(done), 64'd1);
      checkOutput("overrun run iterations", 64'(iterations), 64'd3);
      checkOutput("overrun held at done", 64'(overrun), 64'd1);
      exp_buf = ~exp_buf;
      run_steps(32'd1, 8, 0);

      // Reset in the middle of a sweep.
      applyStimulus(1'b1, 32'd10, 1'b0);
      wait_cycle();
      applyStimulus(1'b0, 32'd10, 1'b0);
      for (int i = 0; i < 10 && !(rd_en && rd_row == 2'd2); i++) wait_cycle();
      checkOutput("reached rd_row 2", 64'({rd_en, rd_row}), 64'({1'b1, 2'd2}));
      #2 rst = 1'b0;
      #1;
      checkOutput("async reset outputs", packOutputs(), 64'd0);
      exp_buf = 1'b0;
      wait_cycle();
      wait_cycle();
      rst = 1'b1;
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         wait_cycle();
         if (wr_en || rd_en) cnt++;
      end
      checkOutput("no access after reset", 64'(cnt), 64'd0);
      run_table();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
